// File: rtl/lfsr_checker.sv
// lfsr_checker
//   Receive-side checker for a 20-bit Fibonacci LFSR serial stream (taps 20,17).
//   Seeds its history from the first 20 received bits. It then checks a run of
//   predicted bits before declaring lock. While locked it free-runs its own
//   history, so every flipped bit on the link is counted exactly once.
//
//   Optional feature macro: LFSR_CHK_STATS_EN adds the bit_count output.
//
// Ports
//   clk        clock
//   reset_n    asynchronous active-low reset
//   bit_in     received serial bit, sampled when bit_valid=1
//   bit_valid  qualifies bit_in; cycles with bit_valid=0 are ignored
//   clear_err  synchronous clear of err_count (and bit_count)
//   locked     registered lock status
//   err_pulse  registered one-cycle pulse per mismatched bit while locked
//   err_count  registered saturating mismatch count while locked
//   bit_count  [LFSR_CHK_STATS_EN] valid bits checked while locked, wrapping
module lfsr_checker #(
    parameter int unsigned LOCK_CNT = 32,
    parameter int unsigned LOSS_THR = 4,
    parameter int unsigned WINDOW   = 64,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
`ifdef LFSR_CHK_STATS_EN
    ,
    output logic [31:0]      bit_count
`endif
);

    localparam int unsigned MW = $clog2(LOCK_CNT + 1);
    localparam int unsigned WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned EW = $clog2(LOSS_THR + 1);

    typedef enum logic [1:0] {
        ST_SEED,
        ST_VERIFY,
        ST_LOCKED
    } state_e;

    state_e        state_q, state_d;
    logic [19:0]   h_q, h_d;
    logic [4:0]    seed_cnt_q, seed_cnt_d;
    logic [MW-1:0] match_cnt_q, match_cnt_d;
    logic [WW-1:0] win_bits_q, win_bits_d;
    logic [EW-1:0] win_err_q, win_err_d;
    logic          err_ev_q, err_ev_d;
    logic          clr_q;
    logic          locked_q;
    logic          err_pulse_q;
    logic [CNT_W-1:0] err_count_q;

    logic pred;
    logic mismatch;

    assign pred     = h_q[19] ^ h_q[16];
    assign mismatch = bit_in ^ pred;

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        win_bits_d  = win_bits_q;
        win_err_d   = win_err_q;
        err_ev_d    = 1'b0;
        if (bit_valid) begin
            case (state_q)
                ST_SEED: begin
                    h_d = {h_q[18:0], bit_in};
                    if (seed_cnt_q == 5'd19) begin
                        seed_cnt_d = '0;
                        // All-zero history is a dead LFSR state: reseed.
                        if (h_d != '0) begin
                            state_d     = ST_VERIFY;
                            match_cnt_d = '0;
                        end
                    end else begin
                        seed_cnt_d = seed_cnt_q + 5'd1;
                    end
                end
                ST_VERIFY: begin
                    if (mismatch) begin
                        state_d     = ST_SEED;
                        h_d         = '0;
                        seed_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else begin
                        h_d = {h_q[18:0], bit_in};
                        if (match_cnt_q == MW'(LOCK_CNT - 1)) begin
                            state_d     = ST_LOCKED;
                            match_cnt_d = '0;
                            win_bits_d  = '0;
                            win_err_d   = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + MW'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    // Free-run on the prediction so one bad bit is one error.
                    h_d      = {h_q[18:0], pred};
                    err_ev_d = mismatch;
                    // An error on the wrap bit belongs to the new window.
                    if (win_bits_q == WW'(WINDOW - 1)) begin
                        win_bits_d = '0;
                        win_err_d  = EW'(mismatch);
                    end else begin
                        win_bits_d = win_bits_q + WW'(1);
                        win_err_d  = win_err_q + EW'(mismatch);
                    end
                    if (win_err_d == EW'(LOSS_THR)) begin
                        state_d    = ST_SEED;
                        h_d        = '0;
                        seed_cnt_d = '0;
                        win_bits_d = '0;
                        win_err_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_SEED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_SEED;
            h_q         <= '0;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_bits_q  <= '0;
            win_err_q   <= '0;
            err_ev_q    <= 1'b0;
            clr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            win_bits_q  <= win_bits_d;
            win_err_q   <= win_err_d;
            err_ev_q    <= err_ev_d;
            clr_q       <= clear_err;
        end
    end

    // Output stage: events from the bit-sampling edge appear one edge later;
    // clear_err is delayed alongside so a coincident clear still wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            locked_q    <= (state_q == ST_LOCKED);
            err_pulse_q <= err_ev_q;
            if (clr_q) begin
                err_count_q <= '0;
            end else if (err_ev_q && (err_count_q != '1)) begin
                err_count_q <= err_count_q + CNT_W'(1);
            end
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

`ifdef LFSR_CHK_STATS_EN
    logic        stat_ev_q;
    logic [31:0] bit_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_ev_q   <= 1'b0;
            bit_count_q <= '0;
        end else begin
            stat_ev_q <= bit_valid && (state_q == ST_LOCKED);
            if (clr_q) begin
                bit_count_q <= '0;
            end else if (stat_ev_q) begin
                bit_count_q <= bit_count_q + 32'd1;
            end
        end
    end

    assign bit_count = bit_count_q;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker
//   Directed bench for lfsr_checker. A reference generator applies the rule
//   Q(n+1)=Q(n-19)^Q(n-16) and feeds the link. Expected values are worked out by
//   hand from the lock, latency and window rules. err_count is narrowed to 4
//   bits so that saturation is reachable in a short run.
module tb_lfsr_checker;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          bit_in;
    logic          bit_valid;
    logic          clear_err;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_count;
`ifdef LFSR_CHK_STATS_EN
    logic [31:0]   bit_count;
`endif

    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    logic [19:0] g;
    int unsigned lk_idx;

    lfsr_checker #(
        .LOCK_CNT(32),
        .LOSS_THR(4),
        .WINDOW  (64),
        .CNT_W   (CW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bit_in   (bit_in),
        .bit_valid(bit_valid),
        .clear_err(clear_err),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_count(err_count)
`ifdef LFSR_CHK_STATS_EN
        ,
        .bit_count(bit_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic b, input logic v);
        bit_in    = b;
        bit_valid = v;
        @(posedge clk);
        #1;
        if (v) lk_idx++;
    endtask

    task automatic gen(output logic b);
        b = g[19] ^ g[16];
        g = {g[18:0], b};
    endtask

    task automatic send_good();
        logic b;
        gen(b);
        drive(b, 1'b1);
    endtask

    task automatic send_bad();
        logic b;
        gen(b);
        drive(~b, 1'b1);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        clear_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        lk_idx = 0;

        // 1: reset values, then lock from a clean stream.
        do_reset();
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_pulse", 32'(err_pulse), 32'd0);
        check("rst_count", 32'(err_count), 32'd0);
        g = 20'hACE15;
        repeat (52) send_good();
        check("t1_locked_52", 32'(locked), 32'd0);
        lk_idx = 0;
        send_good();
        check("t1_locked_53", 32'(locked), 32'd1);
        for (int i = 0; i < 2000; i++) begin
            send_good();
            check("t1_clean_pulse", 32'(err_pulse), 32'd0);
        end
        check("t1_count", 32'(err_count), 32'd0);
        check("t1_locked_end", 32'(locked), 32'd1);

        // 2: one flipped bit costs exactly one error.
        send_bad();
        check("t2_pulse_lat", 32'(err_pulse), 32'd0);
        send_good();
        check("t2_pulse", 32'(err_pulse), 32'd1);
        check("t2_count", 32'(err_count), 32'd1);
        check("t2_locked", 32'(locked), 32'd1);
        for (int i = 0; i < 1000; i++) begin
            send_good();
            check("t2_clean_pulse", 32'(err_pulse), 32'd0);
        end
        check("t2_count_end", 32'(err_count), 32'd1);
        check("t2_locked_end", 32'(locked), 32'd1);

        clear_err = 1'b1;
        drive(1'b0, 1'b0);
        clear_err = 1'b0;
        drive(1'b0, 1'b0);
        check("clr_count", 32'(err_count), 32'd0);

        // 3: four errors in one window drop lock; relock 53 bits later.
        while ((lk_idx % 64) != 0) send_good();
        for (int k = 0; k < 3; k++) begin
            send_bad();
            repeat (4) send_good();
        end
        check("t3_locked_3err", 32'(locked), 32'd1);
        send_bad();
        send_good();
        check("t3_locked_lost", 32'(locked), 32'd0);
        check("t3_count", 32'(err_count), 32'd4);
        repeat (51) send_good();
        check("t3_relock_52", 32'(locked), 32'd0);
        send_good();
        check("t3_relock_53", 32'(locked), 32'd1);
        check("t3_count_kept", 32'(err_count), 32'd4);

        // 4: all-zero stream never locks.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b1);
            if ((i % 50) == 49) check("t4_locked", 32'(locked), 32'd0);
        end
        check("t4_count", 32'(err_count), 32'd0);

        // 5: sparse bit_valid; lock after 52 valid bits plus one edge.
        do_reset();
        g = 20'h12345;
        for (int i = 0; i < 52; i++) begin
            drive(1'($urandom_range(1)), 1'b0);
            drive(1'($urandom_range(1)), 1'b0);
            send_good();
        end
        check("t5_locked_52", 32'(locked), 32'd0);
        drive(1'($urandom_range(1)), 1'b0);
        check("t5_locked", 32'(locked), 32'd1);
        check("t5_count", 32'(err_count), 32'd0);

        // 6: saturation, errors spaced 25 apart (never 4 in 64 bits).
        for (int i = 1; i <= 16; i++) begin
            send_bad();
            send_good();
            check("t6_pulse", 32'(err_pulse), 32'd1);
            check("t6_count", 32'(err_count), (i > 15) ? 32'd15 : 32'(i));
            repeat (23) send_good();
        end
        check("t6_locked", 32'(locked), 32'd1);

        clear_err = 1'b1;
        send_bad();
        clear_err = 1'b0;
        send_good();
        check("t6_clr_count", 32'(err_count), 32'd0);
        check("t6_clr_pulse", 32'(err_pulse), 32'd1);
        repeat (23) send_good();

        send_bad();
        send_good();
        check("t6_pre_rst_count", 32'(err_count), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_locked", 32'(locked), 32'd0);
        check("t6_rst_pulse", 32'(err_pulse), 32'd0);
        check("t6_rst_count", 32'(err_count), 32'd0);
        reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
